// File: rtl/rom_fetch_master.sv
// Credit-limited burst reader: fetches word_cnt_i consecutive words and streams them out in order.
// Define ROM_FETCH_CHECK_EN to add checksum_o (XOR of popped words) and err_o (stray rvalid_i flag).
module rom_fetch_master #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [AW-1:0]    base_addr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             req_o,
    output logic [AW-1:0]    addr_o,
    input  logic [DW-1:0]    rdata_i,
    input  logic             rvalid_i,
`ifdef ROM_FETCH_CHECK_EN
    output logic [DW-1:0]    checksum_o,
    output logic             err_o,
`endif
    output logic [DW-1:0]    data_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t           state;
    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [CW-1:0]    count, outstanding;
    logic [CW-1:0]    count_nxt, out_nxt;
    logic [CW:0]      inflight;
    logic [CNT_W-1:0] left;
    logic [AW-1:0]    next_addr;
    logic             push, pop, issue, start_issue, req_now;

    assign valid_o     = (count != '0);
    assign data_o      = valid_o ? mem[rptr] : '0;
    assign pop         = valid_o & ready_i;
    // Responses with nothing in flight are never buffered.
    assign push        = rvalid_i & (outstanding != '0);
    assign inflight    = {1'b0, outstanding} + {1'b0, count};
    assign issue       = (state == FETCH) && (left != '0) && (inflight < (CW+1)'(FIFO_DEPTH));
    assign start_issue = (state == IDLE) && start_i && (word_cnt_i != '0);
    assign req_now     = issue | start_issue;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (!push && pop)
            count_nxt = count - CW'(1);
        out_nxt = outstanding;
        if (req_now && !push)
            out_nxt = outstanding + CW'(1);
        else if (!req_now && push)
            out_nxt = outstanding - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wptr] <= rdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            req_o       <= 1'b0;
            addr_o      <= '0;
            next_addr   <= '0;
            left        <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            outstanding <= '0;
        end else begin
            done_o      <= 1'b0;
            req_o       <= 1'b0;
            count       <= count_nxt;
            outstanding <= out_nxt;
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (word_cnt_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            // First request goes out straight from the start cycle.
                            busy_o    <= 1'b1;
                            req_o     <= 1'b1;
                            addr_o    <= base_addr_i;
                            next_addr <= base_addr_i + AW'(1);
                            left      <= word_cnt_i - CNT_W'(1);
                            state     <= (word_cnt_i == CNT_W'(1)) ? DRAIN : FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        req_o     <= 1'b1;
                        addr_o    <= next_addr;
                        next_addr <= next_addr + AW'(1);
                        left      <= left - CNT_W'(1);
                        if (left == CNT_W'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Look ahead so done_o lands right after the final handshake.
                    if (out_nxt == '0 && count_nxt == '0) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROM_FETCH_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_o <= '0;
            err_o      <= 1'b0;
        end else if (state == IDLE && start_i) begin
            checksum_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (pop)
                checksum_o <= checksum_o ^ data_o;
            if (rvalid_i && outstanding == '0)
                err_o <= 1'b1;
        end
    end
`endif

endmodule
